// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: immediate extension, operand-B pre-select, stall/flush and a saturating stall counter.
// Optional feature macro: ID_EX_UPPER_IMM_EN enables upper-immediate extension (ext_sel = 2'b10).
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm16,
  input  logic [1:0]    id_ext_sel,
  input  logic          id_alu_src,
  input  logic [RW-1:0] id_rd,
  input  logic [CW-1:0] id_ctrl,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_rt_data,
  output logic [RW-1:0] ex_rd,
  output logic [CW-1:0] ex_ctrl,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned CntW   = 16;
  localparam logic [1:0]  ExtSgn = 2'b01;
`ifdef ID_EX_UPPER_IMM_EN
  localparam logic [1:0]  ExtUpr = 2'b10;
`endif

  logic [DW-1:0] extImm;
  logic [DW-1:0] opBSel;
  logic          cntInc;

  // ID-side immediate extension; reserved encodings fall back to zero-extend
  always_comb begin
    extImm = DW'({16'h0, id_imm16});
    case (id_ext_sel)
      ExtSgn:  extImm = DW'({{16{id_imm16[15]}}, id_imm16});
`ifdef ID_EX_UPPER_IMM_EN
      ExtUpr:  extImm = DW'({id_imm16, 16'h0});
`endif
      default: extImm = DW'({16'h0, id_imm16});
    endcase
  end

  always_comb begin
    opBSel = id_alu_src ? extImm : id_rt_data;
    cntInc = stall && !flush && (stall_cnt != {CntW{1'b1}});
  end

  // Priority: reset, flush (bubble), stall (hold), load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op_a    <= '0;
      ex_op_b    <= '0;
      ex_imm     <= '0;
      ex_rt_data <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_op_a    <= '0;
      ex_op_b    <= '0;
      ex_imm     <= '0;
      ex_rt_data <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ex_op_a    <= id_rs_data;
      ex_op_b    <= opBSel;
      ex_imm     <= extImm;
      ex_rt_data <= id_rt_data;
      ex_rd      <= id_rd;
      ex_ctrl    <= id_ctrl;
    end
  end

  // Saturating performance counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cntInc) begin
      stall_cnt <= stall_cnt + CntW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage plus a stall-counter saturation sequence.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [1:0]  id_ext_sel;
  logic        id_alu_src;
  logic [4:0]  id_rd;
  logic [7:0]  id_ctrl;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_rt_data;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ID_EX_UPPER_IMM_EN
  localparam logic [31:0] UP = 32'h80010000;
`else
  localparam logic [31:0] UP = 32'h00008001;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm16(id_imm16), .id_ext_sel(id_ext_sel),
    .id_alu_src(id_alu_src), .id_rd(id_rd), .id_ctrl(id_ctrl), .stall(stall),
    .flush(flush), .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstN;
    logic        valid;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [1:0]  sel;
    logic        src;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic        stl;
    logic        fls;
    logic        eValid;
    logic [31:0] eA;
    logic [31:0] eB;
    logic [31:0] eImm;
    logic [31:0] eRt;
    logic [4:0]  eRd;
    logic [7:0]  eCtrl;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic checkAll(input int row, input vec_t v);
    chk("ex_valid",   row, 32'(ex_valid),   32'(v.eValid));
    chk("ex_op_a",    row, ex_op_a,         v.eA);
    chk("ex_op_b",    row, ex_op_b,         v.eB);
    chk("ex_imm",     row, ex_imm,          v.eImm);
    chk("ex_rt_data", row, ex_rt_data,      v.eRt);
    chk("ex_rd",      row, 32'(ex_rd),      32'(v.eRd));
    chk("ex_ctrl",    row, 32'(ex_ctrl),    32'(v.eCtrl));
    chk("stall_cnt",  row, 32'(stall_cnt),  32'(v.eCnt));
  endtask

  initial begin
    // rstN valid rs rt imm sel src rd ctrl stall flush | valid opA opB imm rt rd ctrl cnt
    vecs[0]  = '{0,1,32'h11111111,32'h22222222,16'hABCD,2'd1,1,5'd5,8'hFF,0,0, 0,32'h0,32'h0,32'h0,32'h0,5'd0,8'h00,16'd0};
    vecs[1]  = '{0,1,32'h11111111,32'h22222222,16'hABCD,2'd1,1,5'd5,8'hFF,0,0, 0,32'h0,32'h0,32'h0,32'h0,5'd0,8'h00,16'd0};
    vecs[2]  = '{1,1,32'hA0A0A0A0,32'h01020304,16'h8001,2'd0,1,5'd3,8'h12,0,0, 1,32'hA0A0A0A0,32'h00008001,32'h00008001,32'h01020304,5'd3,8'h12,16'd0};
    vecs[3]  = '{1,1,32'hA0A0A0A0,32'h01020304,16'h8001,2'd1,1,5'd3,8'h12,0,0, 1,32'hA0A0A0A0,32'hFFFF8001,32'hFFFF8001,32'h01020304,5'd3,8'h12,16'd0};
    vecs[4]  = '{1,1,32'hA0A0A0A0,32'h01020304,16'h8001,2'd2,1,5'd3,8'h12,0,0, 1,32'hA0A0A0A0,UP,UP,32'h01020304,5'd3,8'h12,16'd0};
    vecs[5]  = '{1,1,32'hA0A0A0A0,32'h01020304,16'h8001,2'd3,1,5'd3,8'h12,0,0, 1,32'hA0A0A0A0,32'h00008001,32'h00008001,32'h01020304,5'd3,8'h12,16'd0};
    vecs[6]  = '{1,1,32'h13579BDF,32'hDEADBEEF,16'h1234,2'd1,0,5'd31,8'hA5,0,0, 1,32'h13579BDF,32'hDEADBEEF,32'h00001234,32'hDEADBEEF,5'd31,8'hA5,16'd0};
    vecs[7]  = '{1,1,32'h0,32'h0,16'h7FFF,2'd1,1,5'd0,8'h01,0,0, 1,32'h0,32'h00007FFF,32'h00007FFF,32'h0,5'd0,8'h01,16'd0};
    vecs[8]  = '{1,0,32'hCAFEF00D,32'h0BADC0DE,16'hFFFF,2'd0,1,5'd7,8'h00,0,0, 0,32'hCAFEF00D,32'h0000FFFF,32'h0000FFFF,32'h0BADC0DE,5'd7,8'h00,16'd0};
    vecs[9]  = '{1,1,32'hAAAA0001,32'hAAAA0002,16'h0010,2'd0,1,5'd10,8'h0A,0,0, 1,32'hAAAA0001,32'h00000010,32'h00000010,32'hAAAA0002,5'd10,8'h0A,16'd0};
    vecs[10] = '{1,1,32'hBBBB0001,32'hBBBB0002,16'hF000,2'd1,1,5'd11,8'h0B,1,0, 1,32'hAAAA0001,32'h00000010,32'h00000010,32'hAAAA0002,5'd10,8'h0A,16'd1};
    vecs[11] = '{1,1,32'hBBBB0001,32'hBBBB0002,16'hF000,2'd1,1,5'd11,8'h0B,1,0, 1,32'hAAAA0001,32'h00000010,32'h00000010,32'hAAAA0002,5'd10,8'h0A,16'd2};
    vecs[12] = '{1,1,32'hBBBB0001,32'hBBBB0002,16'hF000,2'd1,1,5'd11,8'h0B,1,0, 1,32'hAAAA0001,32'h00000010,32'h00000010,32'hAAAA0002,5'd10,8'h0A,16'd3};
    vecs[13] = '{1,1,32'hBBBB0001,32'hBBBB0002,16'hF000,2'd1,1,5'd11,8'h0B,0,0, 1,32'hBBBB0001,32'hFFFFF000,32'hFFFFF000,32'hBBBB0002,5'd11,8'h0B,16'd3};
    vecs[14] = '{1,1,32'hCCCC0001,32'hCCCC0002,16'h5555,2'd0,1,5'd12,8'h0C,1,1, 0,32'h0,32'h0,32'h0,32'h0,5'd0,8'h00,16'd3};
    vecs[15] = '{1,1,32'h00000001,32'h00000002,16'h0003,2'd0,0,5'd2,8'h44,0,0, 1,32'h00000001,32'h00000002,32'h00000003,32'h00000002,5'd2,8'h44,16'd3};
    vecs[16] = '{1,1,32'hDDDD0001,32'hDDDD0002,16'h1111,2'd0,1,5'd13,8'h0D,0,1, 0,32'h0,32'h0,32'h0,32'h0,5'd0,8'h00,16'd3};
    vecs[17] = '{1,1,32'h00000011,32'h00000022,16'hFFFE,2'd1,1,5'd4,8'h77,0,0, 1,32'h00000011,32'hFFFFFFFE,32'hFFFFFFFE,32'h00000022,5'd4,8'h77,16'd3};
    vecs[18] = '{1,1,32'hEEEE0001,32'hEEEE0002,16'h0000,2'd0,0,5'd9,8'h99,1,0, 1,32'h00000011,32'hFFFFFFFE,32'hFFFFFFFE,32'h00000022,5'd4,8'h77,16'd4};
    vecs[19] = '{0,1,32'hEEEE0001,32'hEEEE0002,16'h0000,2'd0,0,5'd9,8'h99,1,0, 0,32'h0,32'h0,32'h0,32'h0,5'd0,8'h00,16'd0};

    rst_n = 1'b0; id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm16 = '0;
    id_ext_sel = '0; id_alu_src = 1'b0; id_rd = '0; id_ctrl = '0; stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 20; i++) begin
      rst_n = vecs[i].rstN;      id_valid = vecs[i].valid;
      id_rs_data = vecs[i].rs;   id_rt_data = vecs[i].rt;
      id_imm16 = vecs[i].imm;    id_ext_sel = vecs[i].sel;
      id_alu_src = vecs[i].src;  id_rd = vecs[i].rd;
      id_ctrl = vecs[i].ctrl;    stall = vecs[i].stl;
      flush = vecs[i].fls;
      @(posedge clk); #1;
      checkAll(i, vecs[i]);
    end

    // Saturation: counter starts from 0 after the reset row, held in stall
    rst_n = 1'b1; stall = 1'b1; flush = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_pre_sat", 100, 32'(stall_cnt), 32'h0000FFFE);
    chk("valid_held",  100, 32'(ex_valid),  32'h0);
    @(posedge clk); #1;
    chk("cnt_sat",     101, 32'(stall_cnt), 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_no_wrap", 102, 32'(stall_cnt), 32'h0000FFFF);
    stall = 1'b0; id_valid = 1'b1; id_rs_data = 32'h12345678; id_ctrl = 8'h5A;
    @(posedge clk); #1;
    chk("cnt_after",   103, 32'(stall_cnt), 32'h0000FFFF);
    chk("load_after",  103, ex_op_a,        32'h12345678);
    chk("ctrl_after",  103, 32'(ex_ctrl),   32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
